// File: rtl/soc_pmem_loader.sv
// soc_pmem_loader: framed byte-stream program loader feeding one port of the
// dual-port program memory. Receives ADDR/CNT header, 16-bit little-endian
// data words and an XOR checksum byte; holds the CPU in reset while loading.
// Optional read-back verification of every written word is enabled by
// defining PMEM_LOADER_VERIFY_EN.
module soc_pmem_loader #(
    parameter int ADDR_MSB = 11
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              load_en,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              ram_en,
    output logic [1:0]        ram_we,
    output logic [ADDR_MSB:0] ram_addr,
    output logic [15:0]       ram_din,
    input  logic [15:0]       ram_dout,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // One past the last legal word address, kept 17 bits wide so that a
    // load ending exactly at the top of memory is representable.
    localparam logic [16:0] DEPTH = 17'd1 << (ADDR_MSB + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_LO,
        S_ADDR_HI,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA_LO,
        S_DATA_HI,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
`ifdef PMEM_LOADER_VERIFY_EN
        ,
        S_VERIFY_RD,
        S_VERIFY_CMP
`endif
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] addr_reg, addr_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [7:0]  chk_reg, chk_next;
    logic [7:0]  lo_reg, lo_next;

    logic        accept;
    logic        busy;
    logic [15:0] hdr_cnt;
    logic [16:0] hdr_end;
    logic        hdr_bad;

    assign accept  = rx_valid & rx_ready;
    assign busy    = !(state_reg inside {S_IDLE, S_DONE, S_ERR});
    // Full word count as it stands once CNT_HI is on the bus.
    assign hdr_cnt = {rx_data, cnt_reg[7:0]};
    assign hdr_end = {1'b0, addr_reg} + {1'b0, hdr_cnt};
    // Start address outside the RAM, or the block running past its end.
    assign hdr_bad = ({1'b0, addr_reg} >= DEPTH) || (hdr_end > DEPTH);

`ifndef PMEM_LOADER_VERIFY_EN
    // Read data is only consumed by the verify path.
    logic unused_dout;
    assign unused_dout = ^ram_dout;
`endif

    // Next-state, header/data capture and running checksum.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        cnt_next   = cnt_reg;
        chk_next   = chk_reg;
        lo_next    = lo_reg;
        if (busy && !load_en) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (load_en) begin
                        state_next = S_ADDR_LO;
                        chk_next   = 8'h00;
                    end
                end
                S_ADDR_LO: begin
                    if (accept) begin
                        addr_next  = {addr_reg[15:8], rx_data};
                        chk_next   = chk_reg ^ rx_data;
                        state_next = S_ADDR_HI;
                    end
                end
                S_ADDR_HI: begin
                    if (accept) begin
                        addr_next  = {rx_data, addr_reg[7:0]};
                        chk_next   = chk_reg ^ rx_data;
                        state_next = S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (accept) begin
                        cnt_next   = {cnt_reg[15:8], rx_data};
                        chk_next   = chk_reg ^ rx_data;
                        state_next = S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (accept) begin
                        cnt_next = hdr_cnt;
                        chk_next = chk_reg ^ rx_data;
                        if (hdr_bad)
                            state_next = S_ERR;
                        else if (hdr_cnt == 16'd0)
                            state_next = S_CHK;
                        else
                            state_next = S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (accept) begin
                        lo_next    = rx_data;
                        chk_next   = chk_reg ^ rx_data;
                        state_next = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    if (accept) begin
                        chk_next   = chk_reg ^ rx_data;
                        state_next = S_WRITE;
                    end
                end
                S_WRITE: begin
                    addr_next = addr_reg + 16'd1;
                    cnt_next  = cnt_reg - 16'd1;
`ifdef PMEM_LOADER_VERIFY_EN
                    state_next = S_VERIFY_RD;
`else
                    state_next = (cnt_reg == 16'd1) ? S_CHK : S_DATA_LO;
`endif
                end
`ifdef PMEM_LOADER_VERIFY_EN
                S_VERIFY_RD: begin
                    state_next = S_VERIFY_CMP;
                end
                S_VERIFY_CMP: begin
                    // ram_din still holds the word just written.
                    if (ram_dout != ram_din)
                        state_next = S_ERR;
                    else
                        state_next = (cnt_reg == 16'd0) ? S_CHK : S_DATA_LO;
                end
`endif
                S_CHK: begin
                    if (accept)
                        state_next = (rx_data == chk_reg) ? S_DONE : S_ERR;
                end
                S_DONE, S_ERR: begin
                    if (!load_en)
                        state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // State registers plus outputs registered from the upcoming state.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            addr_reg  <= 16'h0000;
            cnt_reg   <= 16'h0000;
            chk_reg   <= 8'h00;
            lo_reg    <= 8'h00;
            rx_ready  <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 2'b00;
            ram_addr  <= '0;
            ram_din   <= 16'h0000;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            cnt_reg   <= cnt_next;
            chk_reg   <= chk_next;
            lo_reg    <= lo_next;
            rx_ready  <= state_next inside {S_ADDR_LO, S_ADDR_HI, S_CNT_LO, S_CNT_HI,
                                            S_DATA_LO, S_DATA_HI, S_CHK};
            cpu_hold  <= !(state_next inside {S_IDLE, S_DONE, S_ERR});
`ifdef PMEM_LOADER_VERIFY_EN
            ram_en    <= (state_next == S_WRITE) || (state_next == S_VERIFY_RD);
`else
            ram_en    <= (state_next == S_WRITE);
`endif
            ram_we    <= (state_next == S_WRITE) ? 2'b11 : 2'b00;
            // Address and data are only updated for a write and hold otherwise.
            if (state_next == S_WRITE) begin
                ram_addr <= addr_reg[ADDR_MSB:0];
                ram_din  <= {rx_data, lo_reg};
            end
            // done/err survive into IDLE and clear when a new load starts
            // or when a load in progress is aborted.
            if (state_next == S_DONE)
                done <= 1'b1;
            else if (state_next == S_ADDR_LO || (busy && state_next == S_IDLE))
                done <= 1'b0;
            if (state_next == S_ERR)
                err <= 1'b1;
            else if (state_next == S_ADDR_LO || (busy && state_next == S_IDLE))
                err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_soc_pmem_loader.sv
// Self-checking bench for soc_pmem_loader: directed frames from the test plan,
// randomized frames with random rx_valid gaps, abort and async-reset cases,
// and (with PMEM_LOADER_VERIFY_EN) a corrupted read-back.
module tb_soc_pmem_loader;

    localparam int ADDR_MSB = 11;
    localparam int DEPTH    = 1 << (ADDR_MSB + 1);
`ifdef PMEM_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic              mclk = 1'b0;
    logic              reset_n = 1'b1;
    logic              load_en;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              ram_en;
    logic [1:0]        ram_we;
    logic [ADDR_MSB:0] ram_addr;
    logic [15:0]       ram_din;
    logic [15:0]       ram_dout = 16'h0000;
    logic              cpu_hold;
    logic              done;
    logic              err;

    soc_pmem_loader #(.ADDR_MSB(ADDR_MSB)) dut (
        .mclk     (mclk),
        .reset_n  (reset_n),
        .load_en  (load_en),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 mclk = ~mclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // RAM model: synchronous write, one-cycle read; can corrupt one readback.
    logic [15:0] mem [0:DEPTH-1];
    int          ram_rd_cnt = 0;
    int          corrupt_at = -1;
    always @(posedge mclk) begin
        if (ram_en) begin
            if (ram_we == 2'b11) begin
                mem[ram_addr] <= ram_din;
            end else if (ram_we == 2'b00) begin
                ram_dout   <= mem[ram_addr] ^ ((ram_rd_cnt == corrupt_at) ? 16'h0001 : 16'h0000);
                ram_rd_cnt <= ram_rd_cnt + 1;
            end
        end
    end

    // Monitor: logs RAM writes/reads and any cpu_hold drop inside a frame.
    int   wr_addr_q[$];
    int   wr_data_q[$];
    int   rd_seen = 0;
    int   hold_low_cnt = 0;
    logic in_frame = 1'b0;
    always @(negedge mclk) begin
        if (ram_en && ram_we == 2'b11) begin
            wr_addr_q.push_back(int'(ram_addr));
            wr_data_q.push_back(int'(ram_din));
        end
        if (ram_en && ram_we == 2'b00)
            rd_seen <= rd_seen + 1;
        if (in_frame && !cpu_hold && !done && !err)
            hold_low_cnt <= hold_low_cnt + 1;
    end

    logic [7:0] frame_q[$];
    int         exp_wa[$];
    int         exp_wd[$];
    bit         exp_done;
    bit         exp_err;

    task automatic build_frame(input int addr, input int n, input logic [7:0] flip);
        logic [15:0] a16, n16, w;
        logic [7:0]  x;
        a16 = 16'(addr);
        n16 = 16'(n);
        frame_q.delete();
        frame_q.push_back(a16[7:0]);
        frame_q.push_back(a16[15:8]);
        frame_q.push_back(n16[7:0]);
        frame_q.push_back(n16[15:8]);
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            frame_q.push_back(w[7:0]);
            frame_q.push_back(w[15:8]);
        end
        x = 8'h00;
        foreach (frame_q[i]) x ^= frame_q[i];
        frame_q.push_back(x ^ flip);
    endtask

    // Reference: what a load of frame_q must write and how it must end.
    task automatic model_frame(input int corrupt_k);
        int         a, n;
        logic [7:0] x;
        exp_wa.delete();
        exp_wd.delete();
        a = int'({frame_q[1], frame_q[0]});
        n = int'({frame_q[3], frame_q[2]});
        if (a >= DEPTH || a + n > DEPTH) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_wa.push_back(a + i);
            exp_wd.push_back(int'({frame_q[5 + 2 * i], frame_q[4 + 2 * i]}));
            if (VERIFY && i == corrupt_k) begin
                exp_done = 1'b0;
                exp_err  = 1'b1;
                return;
            end
        end
        x = 8'h00;
        for (int i = 0; i < frame_q.size() - 1; i++) x ^= frame_q[i];
        exp_done = (x == frame_q[frame_q.size() - 1]);
        exp_err  = !exp_done;
    endtask

    // Streams frame_q; mode 0 = always valid, 1 = random, 2 = every other cycle.
    task automatic drive_frame(input int mode, input bit stop_on_write, output bit stopped);
        int idx = 0;
        int cyc = 0;
        bit hs;
        stopped = 1'b0;
        while (idx < frame_q.size() && cyc < 4000) begin
            @(negedge mclk);
            if (done || err) break;
            if (stop_on_write && ram_en && ram_we == 2'b11) begin
                stopped = 1'b1;
                break;
            end
            case (mode)
                1:       rx_valid = 1'($urandom_range(0, 1));
                2:       rx_valid = (cyc % 2 == 0);
                default: rx_valid = 1'b1;
            endcase
            rx_data = frame_q[idx];
            hs = rx_valid && rx_ready;
            @(posedge mclk);
            #1;
            if (hs) idx++;
            cyc++;
        end
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int mode, input int corrupt_k);
        int wbase, rbase, hbase, nw, waits, exp_reads;
        bit stopped;
        model_frame(corrupt_k);
        exp_reads = VERIFY ? exp_wa.size() : 0;
        wbase = wr_addr_q.size();
        rbase = rd_seen;
        corrupt_at = (corrupt_k >= 0) ? ram_rd_cnt + corrupt_k : -1;
        @(negedge mclk);
        load_en = 1'b1;
        @(negedge mclk);
        in_frame = 1'b1;
        hbase = hold_low_cnt;
        drive_frame(mode, 1'b0, stopped);
        waits = 0;
        while (!(done || err) && waits < 20) begin
            @(negedge mclk);
            waits++;
        end
        in_frame = 1'b0;
        nw = wr_addr_q.size() - wbase;
        check({tag, "_term"}, 32'(done | err), 32'd1);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_hold_gap"}, 32'(hold_low_cnt - hbase), 32'd0);
        check({tag, "_nwrites"}, 32'(nw), 32'(exp_wa.size()));
        check({tag, "_nreads"}, 32'(rd_seen - rbase), 32'(exp_reads));
        for (int i = 0; i < exp_wa.size() && i < nw; i++) begin
            check($sformatf("%s_waddr%0d", tag, i), 32'(wr_addr_q[wbase + i]), 32'(exp_wa[i]));
            check($sformatf("%s_wdata%0d", tag, i), 32'(wr_data_q[wbase + i]), 32'(exp_wd[i]));
        end
        $display("frame %s: addr=0x%02h%02h cnt=0x%02h%02h writes=%0d done=%0b err=%0b",
                 tag, frame_q[1], frame_q[0], frame_q[3], frame_q[2], nw, done, err);
        @(negedge mclk);
        load_en = 1'b0;
        @(negedge mclk);
        @(negedge mclk);
        check({tag, "_done_held"}, 32'(done), 32'(exp_done));
        check({tag, "_err_held"}, 32'(err), 32'(exp_err));
        check({tag, "_idle_hold"}, 32'(cpu_hold), 32'd0);
        corrupt_at = -1;
    endtask

    int          a_rnd, n_rnd, wbase_t;
    logic [7:0]  flip_rnd;
    bit          stopped_t;

    initial begin
        load_en  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge mclk);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_din", 32'(ram_din), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset_n = 1'b1;

        // Test-plan frame with a hand-computed checksum, then a bad checksum.
        frame_q = '{8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h52};
        run_frame("tp_good", 0, -1);
        frame_q = '{8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h53};
        run_frame("tp_badchk", 0, -1);

        // Address-range boundaries and empty loads.
        build_frame(16'h0FFF, 2, 8'h00);
        run_frame("ovf", 1, -1);
        build_frame(16'h0FFE, 2, 8'h00);
        run_frame("top", 1, -1);
        build_frame(16'h0005, 0, 8'h00);
        run_frame("n0", 0, -1);
        build_frame(16'h1000, 0, 8'h00);
        run_frame("hibit", 0, -1);

        // Randomized frames.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       a_rnd = DEPTH - int'($urandom_range(0, 7));
                1:       a_rnd = int'($urandom_range(0, 16'hFFFF));
                default: a_rnd = int'($urandom_range(0, DEPTH - 1));
            endcase
            n_rnd    = int'($urandom_range(0, 6));
            flip_rnd = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            build_frame(a_rnd, n_rnd, flip_rnd);
            run_frame($sformatf("rnd%0d", i), int'($urandom_range(0, 2)), -1);
        end

        // Abort: drop load_en during the first word's write.
        build_frame(16'h0100, 3, 8'h00);
        wbase_t = wr_addr_q.size();
        @(negedge mclk);
        load_en = 1'b1;
        @(negedge mclk);
        drive_frame(2, 1'b1, stopped_t);
        check("abort_reached_write", 32'(stopped_t), 32'd1);
        load_en = 1'b0;
        @(negedge mclk);
        check("abort_cpu_hold", 32'(cpu_hold), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        check("abort_rx_ready", 32'(rx_ready), 32'd0);
        check("abort_ram_en", 32'(ram_en), 32'd0);
        repeat (4) @(negedge mclk);
        check("abort_nwrites", 32'(wr_addr_q.size() - wbase_t), 32'd1);
        if (wr_addr_q.size() > wbase_t) begin
            check("abort_waddr", 32'(wr_addr_q[wbase_t]), 32'h100);
            check("abort_wdata", 32'(wr_data_q[wbase_t]), 32'({frame_q[5], frame_q[4]}));
        end
        $display("abort: writes=%0d cpu_hold=%0b done=%0b err=%0b",
                 wr_addr_q.size() - wbase_t, cpu_hold, done, err);

        // Asynchronous reset in the middle of a write.
        build_frame(16'h0200, 4, 8'h00);
        @(negedge mclk);
        load_en = 1'b1;
        @(negedge mclk);
        drive_frame(0, 1'b1, stopped_t);
        check("arst_reached_write", 32'(stopped_t), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_rx_ready", 32'(rx_ready), 32'd0);
        check("arst_ram_en", 32'(ram_en), 32'd0);
        check("arst_ram_we", 32'(ram_we), 32'd0);
        check("arst_ram_addr", 32'(ram_addr), 32'd0);
        check("arst_ram_din", 32'(ram_din), 32'd0);
        check("arst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        $display("async reset: ram_addr=0x%0h cpu_hold=%0b", ram_addr, cpu_hold);
        load_en = 1'b0;
        @(negedge mclk);
        reset_n = 1'b1;
        @(negedge mclk);
        check("arst_idle_hold", 32'(cpu_hold), 32'd0);

        // Loader still works after the asynchronous reset.
        build_frame(16'h0300, 2, 8'h00);
        run_frame("post_rst", 1, -1);

`ifdef PMEM_LOADER_VERIFY_EN
        // Second word reads back with bit 0 flipped.
        build_frame(16'h0020, 4, 8'h00);
        run_frame("verify_corrupt", 0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/soc_pmem_loader.md
Name: soc_pmem_loader

Overview:
- Byte-stream program loader sitting directly upstream of the dual-port program memory; drives one RAM port (en/we/addr/din, active-high) while the CPU owns the other port.
- Accepts a framed image over a valid/ready byte interface, assembles little-endian 16-bit words and writes them sequentially.
- Verifies an XOR checksum and holds the CPU in reset while loading.

Parameters:
- ADDR_MSB, 11, MSB of the RAM word address; RAM depth is 2^(ADDR_MSB+1) words.

Ports:
- mclk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- load_en  in  1  loader enable; low aborts the load and returns to IDLE.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte; a transfer occurs when rx_valid & rx_ready at a clock edge.
- ram_en  out  1  RAM port enable, active high.
- ram_we  out  2  RAM byte write enables, active high.
- ram_addr  out  ADDR_MSB+1  RAM word address.
- ram_din  out  16  RAM write data.
- ram_dout  in  16  RAM read data, one-cycle read latency; used only with the optional feature.
- cpu_hold  out  1  high while busy; keeps the CPU in reset.
- done  out  1  load completed with good checksum.
- err  out  1  load failed.

Behaviour:
- Reset values: rx_ready=0, ram_en=0, ram_we=0, ram_addr=0, ram_din=0, cpu_hold=0, done=0, err=0. State is IDLE; address register, count register and checksum register are all 0.
- Frame format: ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, then 2·N data bytes (LSB first per word), then CHK. CHK equals the XOR of every preceding frame byte.
- States: IDLE → ADDR_LO → ADDR_HI → CNT_LO → CNT_HI → DATA_LO ↔ DATA_HI → WRITE → (DATA_LO | CHK) → DONE | ERR.
- IDLE: rx_ready=0, cpu_hold=0. When load_en=1, go to ADDR_LO next cycle and clear done, err and the checksum.
- Header, data and CHK states: rx_ready=1. Each accepted byte advances the state and XORs into the checksum; CHK itself is compared, not accumulated.
- After CNT_HI is accepted:
  - ADDR bits [15:ADDR_MSB+1] nonzero → ERR.
  - addr+N > 2^(ADDR_MSB+1), computed 17 bits wide → ERR.
  - N=0 → CHK.
  - Otherwise → DATA_LO.
  - No RAM write ever occurs on a header error.
- DATA_HI accepted → WRITE. WRITE lasts exactly one cycle: ram_en=1, ram_we=2'b11, ram_addr=current, ram_din={hi,lo}, rx_ready=0. Then address +1 and count −1. Count reaching 0 → CHK, else → DATA_LO.
- Byte-to-write latency: 1 cycle after DATA_HI is accepted. Peak throughput: 1 word per 3 cycles.
- Outside WRITE (and the VERIFY states below): ram_en=0, ram_we=0. ram_addr and ram_din hold their last values.
- CHK byte accepted: match → DONE, mismatch → ERR. Words already written stay in RAM.
- DONE: done=1, cpu_hold=0, rx_ready=0. ERR: err=1, cpu_hold=0, rx_ready=0. Both hold until load_en=0, then go to IDLE. done and err stay set in IDLE until the next load starts.
- cpu_hold=1 in every state except IDLE, DONE and ERR.
- load_en=0 in any busy state: next cycle is IDLE. Any WRITE in progress completes that cycle, with no further writes. done=0, err=0.
- rx_valid=0 stalls: the state is held with no timeout.
- Last write at address 2^(ADDR_MSB+1)−1 is legal and must not be flagged as an error.

Optional Feature:
- Macro: PMEM_LOADER_VERIFY_EN.
- When defined: WRITE → VERIFY_RD (ram_en=1, ram_we=0, same address) → VERIFY_CMP (ram_dout compared with the written word).
  - Mismatch → ERR immediately; remaining bytes are not accepted.
  - Match → continue as normal.
  - Throughput becomes 1 word per 5 cycles.
- When undefined: no VERIFY states and ram_dout is ignored.

Test Plan:
- Frame addr=0x0010, N=2, words 0x1234, 0xABCD, CHK=0x10^0x00^0x02^0x00^0x34^0x12^0xCD^0xAB → writes 0x1234@0x010, 0xABCD@0x011 with ram_we=2'b11; done=1, err=0; cpu_hold high from start to DONE.
- Same frame with CHK xored by 0x01 → both words written, err=1, done=0.
- addr=0x0FFF, N=2 (ADDR_MSB=11) → err=1 after CNT_HI, zero ram_en pulses. Variant addr=0x0FFE, N=2 → done=1 with the last write at 0x0FFF.
- N=0, CHK=addr/count XOR → done=1, no writes. addr=0x1000 → err=1.
- rx_valid toggling every other cycle plus load_en dropped after the first word's WRITE → exactly one write, IDLE next cycle, done=err=cpu_hold=0; reset_n pulsed mid-frame → all outputs return to reset values asynchronously.
- With PMEM_LOADER_VERIFY_EN, RAM model corrupting bit 0 on readback of the 2nd word → read cycle observed after each write, err=1 after the 2nd word, rx_ready=0 thereafter.
